ir_led_sink_ctrl: RTL and testbench

//  Multi-channel successor to the single IR open-drain sink pad: drives NCH

---
 rtl/ir_led_sink_ctrl.sv | 140 ++++++++++++++
 tb/tb_ir_led_sink_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ir_led_sink_ctrl.sv
`timescale 1ns/1ps
// Multi-channel IR/LED current-sink controller: per-channel PWM gating, LSB-first
// soft-start ramp of the current code, and a synchronised bias-valid interlock.
module ir_led_sink_ctrl #(
  parameter int NCH      = 3,
  parameter int CBITW    = 10,
  parameter int PWMW     = 8,
  parameter int RAMP_DIV = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  nref,
  input  logic                  vref_in,
  input  logic                  poc,
  input  logic [NCH-1:0]        ch_en,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_ch,
  input  logic [PWMW-1:0]       cfg_duty,
  input  logic [CBITW-1:0]      cfg_cbit,
  output logic [NCH*CBITW-1:0]  sink_en,
  output logic [NCH-1:0]        ch_on,
  output logic                  bias_ok
);

  localparam int LVLW = $clog2(CBITW + 1);
  localparam int PSW  = $clog2(RAMP_DIV);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RAMP = 2'd1,
    ST_ON   = 2'd2
  } state_t;

  logic             bias_meta;
  logic [PWMW-1:0]  cnt;
  logic [PSW-1:0]   presc;
  logic             tick;

  assign tick = (presc == PSW'(RAMP_DIV - 1));

  // Shared timing: bias synchroniser, free-running PWM counter, ramp prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_meta <= 1'b0;
      bias_ok   <= 1'b0;
      cnt       <= '0;
      presc     <= '0;
    end else begin
      bias_meta <= nref & vref_in & ~poc;
      bias_ok   <= bias_meta;
      cnt       <= cnt + 1'b1;
      presc     <= tick ? '0 : presc + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      state_t           state, state_next;
      logic [LVLW-1:0]  lvl, lvl_next;
      logic [PWMW-1:0]  duty;
      logic [CBITW-1:0] target;
      logic [CBITW-1:0] lvl_mask;
      logic [CBITW-1:0] cur;
      logic [CBITW-1:0] sink_reg, sink_next;
      logic             pwm;
      logic             cfg_hit;

      // cfg_ch values at or above NCH match no channel, so such writes are dropped.
      assign cfg_hit = cfg_we && (cfg_ch == 3'(gi));
      assign pwm     = (cnt < duty);

      always_comb begin
        lvl_mask = '0;
        for (int b = 0; b < CBITW; b++) begin
          lvl_mask[b] = (LVLW'(b) < lvl);
        end
      end

      assign cur = target & lvl_mask;

      always_comb begin
        state_next = state;
        lvl_next   = lvl;
        case (state)
          ST_OFF: begin
            lvl_next = '0;
            if (ch_en[gi] && bias_ok) state_next = ST_RAMP;
          end
          ST_RAMP: begin
            if (tick) begin
              if (lvl == LVLW'(CBITW - 1)) begin
                lvl_next   = LVLW'(CBITW);
                state_next = ST_ON;
              end else begin
                lvl_next = lvl + 1'b1;
              end
            end
          end
          ST_ON: begin
            lvl_next = LVLW'(CBITW);
          end
          default: begin
            state_next = ST_OFF;
            lvl_next   = '0;
          end
        endcase
        if (!ch_en[gi] || !bias_ok) begin
          state_next = ST_OFF;
          lvl_next   = '0;
        end
      end

      // Gate on the next state so the pad releases on the same edge the FSM drops to OFF.
      assign sink_next = (state_next == ST_OFF) ? '0 : (cur & {CBITW{pwm}});

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state    <= ST_OFF;
          lvl      <= '0;
          duty     <= '0;
          target   <= '0;
          sink_reg <= '0;
        end else begin
          state    <= state_next;
          lvl      <= lvl_next;
          sink_reg <= sink_next;
          if (cfg_hit) begin
            duty   <= cfg_duty;
            target <= cfg_cbit;
          end
        end
      end

      assign sink_en[gi*CBITW +: CBITW] = sink_reg;
      assign ch_on[gi]                  = (state == ST_ON);
    end
  endgenerate

endmodule

// File: tb/tb_ir_led_sink_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for ir_led_sink_ctrl: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ir_led_sink_ctrl;
  localparam int NCH = 3, CBITW = 10, PWMW = 8, RAMP_DIV = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 nref = 1'b1;
  logic                 vref_in = 1'b1;
  logic                 poc = 1'b0;
  logic [NCH-1:0]       ch_en = '0;
  logic                 cfg_we = 1'b0;
  logic [2:0]           cfg_ch = '0;
  logic [PWMW-1:0]      cfg_duty = '0;
  logic [CBITW-1:0]     cfg_cbit = '0;
  logic [NCH*CBITW-1:0] sink_en;
  logic [NCH-1:0]       ch_on;
  logic                 bias_ok;

  ir_led_sink_ctrl #(.NCH(NCH), .CBITW(CBITW), .PWMW(PWMW), .RAMP_DIV(RAMP_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .nref(nref), .vref_in(vref_in), .poc(poc),
    .ch_en(ch_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_duty(cfg_duty),
    .cfg_cbit(cfg_cbit), .sink_en(sink_en), .ch_on(ch_on), .bias_ok(bias_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [127:0] name;
    logic [29:0]  sink;
    logic [29:0]  smask;
    logic [2:0]   on;
    logic [2:0]   omask;
    logic         bok;
    logic         bmask;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  localparam logic [29:0] ALL = 30'h3FFF_FFFF;
  localparam logic [29:0] M0  = 30'h0000_03FF;
  localparam logic [29:0] M01 = 30'h000F_FFFF;

  // Edges since the latest reset release.
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [29:0] pk(input logic [9:0] c2, input logic [9:0] c1, input logic [9:0] c0);
    return {c2, c1, c0};
  endfunction

  task automatic push(input int c, input logic [127:0] nm, input logic [29:0] s, input logic [29:0] sm,
                      input logic [2:0] o, input logic [2:0] om, input logic b, input logic bm);
    exp_t x;
    x.cyc = c; x.name = nm; x.sink = s; x.smask = sm;
    x.on = o; x.omask = om; x.bok = b; x.bmask = bm;
    exp_q.push_back(x);
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic cfg_write(input logic [2:0] ch, input logic [7:0] d, input logic [9:0] cb);
    cfg_we = 1'b1; cfg_ch = ch; cfg_duty = d; cfg_cbit = cb;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Monitor: compare every expectation whose cycle has arrived.
  always @(negedge clk) begin
    while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      tests_run++;
      if (e.cyc != cyc) begin
        tests_failed++;
        $display("FAIL %0s: slot for cycle %0d skipped, now cycle %0d", e.name, e.cyc, cyc);
      end else if (((sink_en & e.smask) !== (e.sink & e.smask)) ||
                   ((ch_on & e.omask) !== (e.on & e.omask)) ||
                   ((bias_ok & e.bmask) !== (e.bok & e.bmask))) begin
        tests_failed++;
        $display("FAIL %0s @%0d: sink_en=%h ch_on=%b bias_ok=%b, required sink_en=%h(mask %h) ch_on=%b(mask %b) bias_ok=%b(mask %b)",
                 e.name, cyc, sink_en, ch_on, bias_ok, e.sink, e.smask, e.on, e.omask, e.bok, e.bmask);
      end else begin
        $display("PASS %0s @%0d: sink_en=%h ch_on=%b bias_ok=%b", e.name, cyc, sink_en, ch_on, bias_ok);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    // Reset and bias synchroniser latency.
    push(1, "reset_c1", '0, ALL, 3'b000, 3'b111, 1'b0, 1'b1);
    push(2, "bias_c2",  '0, ALL, 3'b000, 3'b111, 1'b1, 1'b1);
    // ch0 soft start: ticks at edges 16,32,...,160; sink_en lags lvl by one edge.
    for (int m = 1; m <= 9; m++) begin
      push(16*m,     "ramp_pre",  pk(10'h0, 10'h0, 10'((1 << (m-1)) - 1)), M0, 3'b000, 3'b000, 1'b0, 1'b0);
      push(16*m + 1, "ramp_step", pk(10'h0, 10'h0, 10'((1 << m) - 1)),     M0, 3'b000, 3'b000, 1'b0, 1'b0);
    end
    push(159, "not_on_yet", '0, '0, 3'b000, 3'b011, 1'b0, 1'b0);
    push(160, "ramp_pre",   pk(10'h0, 10'h0, 10'h1FF), M0, 3'b011, 3'b011, 1'b1, 1'b1);
    push(161, "ramp_full",  pk(10'h0, 10'h0, 10'h3FF), M0, 3'b011, 3'b011, 1'b1, 1'b1);
    // PWM gating: ch0 duty 255, ch1 duty 64 target 155.
    push(256, "duty_max_gap", pk(10'h0, 10'h0,   10'h0),   M0,  3'b011, 3'b011, 1'b1, 1'b1);
    push(257, "pwm_cnt0",     pk(10'h0, 10'h155, 10'h3FF), M01, 3'b011, 3'b011, 1'b1, 1'b1);
    push(320, "pwm_cnt63",    pk(10'h0, 10'h155, 10'h3FF), M01, 3'b011, 3'b011, 1'b1, 1'b1);
    push(321, "pwm_cnt64",    pk(10'h0, 10'h0,   10'h3FF), M01, 3'b011, 3'b011, 1'b1, 1'b1);
    push(512, "pwm_cnt255",   pk(10'h0, 10'h0,   10'h0),   M01, 3'b011, 3'b011, 1'b1, 1'b1);
    push(513, "pwm_wrap",     pk(10'h0, 10'h155, 10'h3FF), M01, 3'b011, 3'b011, 1'b1, 1'b1);
    // Out-of-range channel write changes nothing.
    push(531, "bad_ch_write", pk(10'h0, 10'h155, 10'h3FF), ALL, 3'b011, 3'b111, 1'b1, 1'b1);
    // Target change while ON takes effect the cycle after the write.
    push(770, "tgt_old", pk(10'h0, 10'h155, 10'h3FF), ALL, 3'b011, 3'b111, 1'b1, 1'b1);
    push(771, "tgt_new", pk(10'h0, 10'h3C3, 10'h3FF), ALL, 3'b011, 3'b111, 1'b1, 1'b1);
    // poc pulse: interlock drops, channels go OFF, then ramp restarts from lvl 0.
    push(801, "poc_sync",   pk(10'h0, 10'h3C3, 10'h3FF), ALL, 3'b011, 3'b111, 1'b0, 1'b1);
    push(802, "poc_off",    '0, ALL, 3'b000, 3'b111, 1'b1, 1'b1);
    push(816, "restart_l0", '0, ALL, 3'b000, 3'b111, 1'b1, 1'b1);
    push(817, "restart_l1", pk(10'h0, 10'h001, 10'h001), ALL, 3'b000, 3'b111, 1'b1, 1'b1);
    push(859, "mid_ramp",   pk(10'h0, 10'h000, 10'h007), ALL, 3'b000, 3'b111, 1'b1, 1'b1);
    // Reset asserted between edges must clear outputs before the next edge.
    push(860, "async_rst",  '0, ALL, 3'b000, 3'b111, 1'b0, 1'b1);

    rst_n = 1'b1;
    at_cyc(2);
    ch_en[0] = 1'b1;
    cfg_write(3'd0, 8'd255, 10'h3FF);
    ch_en[1] = 1'b1;
    cfg_write(3'd1, 8'd64, 10'h155);
    at_cyc(529);
    cfg_write(3'd5, 8'd0, 10'h000);
    at_cyc(769);
    cfg_write(3'd1, 8'd64, 10'h3C3);
    at_cyc(799);
    poc = 1'b1;
    @(negedge clk);
    poc = 1'b0;
    at_cyc(859);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // After reset duty/target are zero: channels still ramp to ON but never sink.
    push(1,   "rst2_c1",      '0, ALL, 3'b000, 3'b111, 1'b0, 1'b1);
    push(2,   "rst2_bias",    '0, ALL, 3'b000, 3'b111, 1'b1, 1'b1);
    push(159, "rst2_ramp",    '0, ALL, 3'b000, 3'b111, 1'b1, 1'b1);
    push(161, "rst2_on_zero", '0, ALL, 3'b011, 3'b111, 1'b1, 1'b1);
    rst_n = 1'b1;
    at_cyc(170);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL leftover: %0d expectations never checked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
